knn_sort_vote: RTL
==================

// Module: knn_sort_vote
// PURPOSE
//  Downstream of knn_core. Consumes a stream of (squared distance, label) pairs for one test point.
//  Keeps the K smallest distances in an ascending insertion-sorted list, then runs a majority vote.
//  Outputs the winning class label to the host register bank.
// PARAMETERS
//  DATA_W   16  coordinate width; distance input is 2*DATA_W wide, matching knn_core KNN_VALUE
//  K        4   neighbour list depth (>=1)
//  LABEL_W  4   class label width
// PORTS
//  clk              in   1          system clock, rising edge
//  rst              in   1          reset, asynchronous, active-low
//  KNN_CLEAR        in   1          start new test point: empty list, go IDLE
//  KNN_VALID        in   1          distance/label pair present
//  KNN_LAST         in   1          qualifies KNN_VALID: final training point of this test point
//  KNN_DIST         in   2*DATA_W   unsigned squared distance
//  KNN_LABEL        in   LABEL_W    label of training point
//  KNN_READY        out  1          pair accepted when KNN_VALID & KNN_READY
//  KNN_BUSY         out  1          vote in progress
//  KNN_COUNT        out  clog2(K+1) occupied list slots
//  KNN_CLASS        out  LABEL_W    voted class
//  KNN_CLASS_VALID  out  1          KNN_CLASS is valid
// BEHAVIOUR
//  Reset (rst=0, async): list empty, all slot valid bits 0, state IDLE, KNN_CLASS=0,
//   KNN_CLASS_VALID=0, KNN_COUNT=0, KNN_BUSY=0. KNN_READY=1 (it is decoded from IDLE).
//  FSM states and outputs:
//   IDLE: READY=1.
//   VOTE: BUSY=1, READY=0.
//   DONE: CLASS_VALID=1, READY=0; holds until KNN_CLEAR.
//  FSM transitions:
//   IDLE -> VOTE on an accepted pair with KNN_LAST=1.
//   VOTE -> DONE after K vote cycles.
//   Any state -> IDLE on KNN_CLEAR.
//  Insertion (IDLE, accepted pair): single-cycle parallel compare/shift into slot[0..K-1].
//   - Empty slots count as +infinity.
//   - New pair goes after all entries with distance <= KNN_DIST (stable on ties).
//   - List full and KNN_DIST >= slot[K-1].dist: pair discarded, list unchanged.
//   - KNN_COUNT increments, saturating at K.
//  Vote: index i = 0..K-1, one per cycle, always K cycles (fixed latency).
//   - cnt_i = number of valid slots whose label equals slot[i].label (K parallel comparators).
//   - Invalid slot i is skipped.
//   - best is replaced only on strictly greater cnt_i, so a tie goes to the label of the nearer neighbour.
//   - cnt width is clog2(K+1); no overflow possible.
//  Latency: LAST pair accepted at edge 0 -> VOTE for cycles 1..K -> CLASS/CLASS_VALID registered at edge K+1.
//  Boundary cases:
//   - KNN_CLEAR has priority over KNN_VALID in the same cycle: the pair is dropped, list empties.
//   - KNN_CLEAR during VOTE aborts: CLASS_VALID stays 0, KNN_CLASS keeps its old value.
//   - KNN_VALID while not IDLE: ignored (READY=0), no state change.
//   - LAST with fewer than K pairs: vote runs over occupied slots only.
//   - A LAST pair that is discarded (list full, too far) still triggers the vote.
//   - rst asserted mid-operation: immediate return to reset values.
// CONFIGURATION
//  KNN_MIN_DIST_EN defined: adds output port KNN_MIN_DIST (2*DATA_W) = slot[0].dist.
//   - Reads all-ones when the list is empty (reset/clear); updates on the same edge as insertion.
//  KNN_MIN_DIST_EN undefined: port and its logic are absent; all other behaviour is identical.
// TESTING (K=4, DATA_W=16)
//  1 dists 9,3,7,1,5 / labels 1,2,1,3,1(LAST)
//    -> list (1,L3),(3,L2),(5,L1),(7,L1); CLASS=1, COUNT=4, CLASS_VALID at edge 5 after LAST
//  2 tie: (1,L2),(2,L5),(3,L5),(4,L2,LAST) -> 2-2 tie, CLASS=2 (nearest wins)
//  3 equal dist: (4,L1),(4,L2),(4,L3,LAST) -> slot order L1,L2,L3; CLASS=1
//  4 short list: (10,L7),(20,L3,LAST) -> COUNT=2, CLASS=7; with KNN_MIN_DIST_EN KNN_MIN_DIST=10
//  5 KNN_CLEAR asserted in 2nd VOTE cycle -> IDLE, READY=1, COUNT=0, CLASS_VALID never rises;
//    CLEAR+VALID same cycle -> COUNT stays 0
//  6 rst=0 between two inserts -> all outputs at reset values; next LAST run votes only post-reset pairs

Source files
------------

// File: rtl/knn_sort_vote.sv
// K-nearest insertion-sorted neighbour list plus fixed-latency majority vote.
// Optional KNN_MIN_DIST_EN exposes the nearest distance on KNN_MIN_DIST.
module knn_sort_vote #(
  parameter int DATA_W  = 16,
  parameter int K       = 4,
  parameter int LABEL_W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    KNN_CLEAR,
  input  logic                    KNN_VALID,
  input  logic                    KNN_LAST,
  input  logic [2*DATA_W-1:0]     KNN_DIST,
  input  logic [LABEL_W-1:0]      KNN_LABEL,
  output logic                    KNN_READY,
  output logic                    KNN_BUSY,
  output logic [$clog2(K+1)-1:0]  KNN_COUNT,
  output logic [LABEL_W-1:0]      KNN_CLASS,
  output logic                    KNN_CLASS_VALID
`ifdef KNN_MIN_DIST_EN
  ,
  output logic [2*DATA_W-1:0]     KNN_MIN_DIST
`endif
);
  localparam int DW = 2*DATA_W;
  localparam int CW = $clog2(K+1);
  localparam int IW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {IDLE, VOTE, DONE} state_t;
  state_t state_q, state_d;

  logic [K-1:0][DW-1:0]      slot_dist;
  logic [K-1:0][LABEL_W-1:0] slot_lbl;
  logic [K-1:0]              slot_vld;
  logic [K-1:0]              le;
  logic                      accept;
  logic [CW-1:0]             idx, best_cnt, vote_cnt;
  logic [IW-1:0]             idx_sel;
  logic [LABEL_W-1:0]        best_lbl;

  assign KNN_READY       = (state_q == IDLE);
  assign KNN_BUSY        = (state_q == VOTE);
  assign KNN_CLASS_VALID = (state_q == DONE);
  assign accept          = KNN_VALID && KNN_READY && !KNN_CLEAR;

`ifdef KNN_MIN_DIST_EN
  assign KNN_MIN_DIST = slot_vld[0] ? slot_dist[0] : '1;
`endif

  // le is a thermometer code over the sorted list: slot j keeps its entry when
  // le[j], takes the new pair at the first clear bit, and shifts down after it.
  for (genvar j = 0; j < K; j++) begin : g_slot
    logic              prev_le, prev_vld;
    logic [DW-1:0]     prev_dist;
    logic [LABEL_W-1:0] prev_lbl;
    logic [DW-1:0]     dist_q;
    logic [LABEL_W-1:0] lbl_q;
    logic              vld_q;

    if (j == 0) begin : g_head
      assign prev_le   = 1'b1;
      assign prev_vld  = 1'b1;
      assign prev_dist = KNN_DIST;
      assign prev_lbl  = KNN_LABEL;
    end else begin : g_body
      assign prev_le   = le[j-1];
      assign prev_vld  = slot_vld[j-1];
      assign prev_dist = slot_dist[j-1];
      assign prev_lbl  = slot_lbl[j-1];
    end

    assign le[j] = vld_q && (dist_q <= KNN_DIST);

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        dist_q <= '0;
        lbl_q  <= '0;
        vld_q  <= 1'b0;
      end else if (KNN_CLEAR) begin
        vld_q  <= 1'b0;
      end else if (accept && !le[j]) begin
        if (prev_le) begin
          dist_q <= KNN_DIST;
          lbl_q  <= KNN_LABEL;
          vld_q  <= 1'b1;
        end else begin
          dist_q <= prev_dist;
          lbl_q  <= prev_lbl;
          vld_q  <= prev_vld;
        end
      end
    end

    assign slot_dist[j] = dist_q;
    assign slot_lbl[j]  = lbl_q;
    assign slot_vld[j]  = vld_q;
  end

  assign idx_sel = idx[IW-1:0];

  always_comb begin
    vote_cnt = '0;
    for (int j = 0; j < K; j++)
      if (slot_vld[j] && (slot_lbl[j] == slot_lbl[idx_sel]))
        vote_cnt = vote_cnt + CW'(1);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && KNN_LAST) state_d = VOTE;
      VOTE:    if (idx == CW'(K))      state_d = DONE;
      default: state_d = state_q;
    endcase
    if (KNN_CLEAR) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Indices 0..K-1 accumulate the best label; index K commits it to KNN_CLASS.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx       <= '0;
      best_cnt  <= '0;
      best_lbl  <= '0;
      KNN_CLASS <= '0;
      KNN_COUNT <= '0;
    end else begin
      if (KNN_CLEAR)                            KNN_COUNT <= '0;
      else if (accept && KNN_COUNT != CW'(K))   KNN_COUNT <= KNN_COUNT + CW'(1);

      if (state_q != VOTE) begin
        idx      <= '0;
        best_cnt <= '0;
        best_lbl <= '0;
      end else if (idx != CW'(K)) begin
        idx <= idx + CW'(1);
        if (slot_vld[idx_sel] && vote_cnt > best_cnt) begin
          best_cnt <= vote_cnt;
          best_lbl <= slot_lbl[idx_sel];
        end
      end else if (!KNN_CLEAR) begin
        KNN_CLASS <= best_lbl;
      end
    end
  end
endmodule
